// File: rtl/fib_sram_ctrl.sv
// Fills a single-port SRAM with F0..F(DEPTH-1), reads it back in order and streams the words out.
// Define FIB_READBACK_CHECK_EN to compare each readback word against a second Fibonacci generator.
module fib_sram_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  mismatch,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_RD_REQ, S_RD_WAIT, S_OUT, S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_inc_d;
    logic [DATA_WIDTH-1:0] a_q, b_q, sum_d;
    logic [DATA_WIDTH:0]   full_sum_d;
    logic                  carry_d;
    logic                  done_q, overflow_q, mem_we_q, mem_oe_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q, out_data_q;
    logic                  out_valid_q, out_last_q;

    always_comb begin
        full_sum_d = {1'b0, a_q} + {1'b0, b_q};
        sum_d      = full_sum_d[DATA_WIDTH-1:0];
        carry_d    = full_sum_d[DATA_WIDTH];
        addr_inc_d = addr_q + 1'b1;
    end

`ifdef FIB_READBACK_CHECK_EN
    logic [DATA_WIDTH-1:0] ca_q, cb_q, csum_d;
    logic                  mismatch_q;

    assign csum_d   = ca_q + cb_q;
    assign mismatch = mismatch_q;
`else
    assign mismatch = 1'b0;
`endif

    // NOTE: every register here uses <= so all state updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            a_q         <= '0;
            b_q         <= DATA_WIDTH'(1);
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_oe_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef FIB_READBACK_CHECK_EN
            ca_q        <= '0;
            cb_q        <= DATA_WIDTH'(1);
            mismatch_q  <= 1'b0;
`endif
        end else begin
            // Strobes and their address/data default low; each state re-asserts what the next one needs.
            done_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_oe_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_WRITE;
                        addr_q     <= '0;
                        a_q        <= '0;
                        b_q        <= DATA_WIDTH'(1);
                        overflow_q <= 1'b0;
                        mem_we_q   <= 1'b1;
`ifdef FIB_READBACK_CHECK_EN
                        mismatch_q <= 1'b0;
`endif
                    end
                end
                S_WRITE: begin
                    a_q <= b_q;
                    b_q <= sum_d;
                    if (carry_d) overflow_q <= 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        state_q  <= S_RD_REQ;
                        addr_q   <= '0;
                        mem_oe_q <= 1'b1;
`ifdef FIB_READBACK_CHECK_EN
                        ca_q     <= '0;
                        cb_q     <= DATA_WIDTH'(1);
`endif
                    end else begin
                        addr_q      <= addr_inc_d;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= addr_inc_d;
                        mem_wdata_q <= b_q;
                    end
                end
                S_RD_REQ: begin
                    state_q    <= S_RD_WAIT;
                    mem_oe_q   <= 1'b1;
                    mem_addr_q <= addr_q;
                end
                S_RD_WAIT: begin
                    state_q     <= S_OUT;
                    out_data_q  <= mem_rdata;
                    out_valid_q <= 1'b1;
                    out_last_q  <= (addr_q == LAST_ADDR);
`ifdef FIB_READBACK_CHECK_EN
                    if (mem_rdata != ca_q) mismatch_q <= 1'b1;
                    ca_q <= cb_q;
                    cb_q <= csum_d;
`endif
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (out_last_q) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q    <= S_RD_REQ;
                            addr_q     <= addr_inc_d;
                            mem_oe_q   <= 1'b1;
                            mem_addr_q <= addr_inc_d;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign mem_we    = mem_we_q;
    assign mem_oe    = mem_oe_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_fib_sram_ctrl.sv
// Self-checking bench for fib_sram_ctrl: two instances (ADDR_WIDTH 4 and 3) each with an SRAM model.
module tb_fib_sram_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, out_ready = 1'b1, sel8 = 1'b0, corrupt4 = 1'b0;
    always #5 clk = ~clk;

`ifdef FIB_READBACK_CHECK_EN
    localparam bit EXP_MIS = 1'b1;
`else
    localparam bit EXP_MIS = 1'b0;
`endif

    logic [7:0] fib16 [16] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
                               8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233, 8'd121, 8'd98};

    logic       busy16, done16, ovf16, mis16, we16, oe16, val16, last16;
    logic [3:0] addr16;
    logic [7:0] wd16, rd16, od16;
    logic       busy8, done8, ovf8, mis8, we8, oe8, val8, last8;
    logic [2:0] addr8;
    logic [7:0] wd8, rd8, od8;
    logic       start16, start8;

    assign start16 = start & ~sel8;
    assign start8  = start & sel8;

    fib_sram_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .busy(busy16), .done(done16),
        .overflow(ovf16), .mismatch(mis16), .mem_we(we16), .mem_oe(oe16),
        .mem_addr(addr16), .mem_wdata(wd16), .mem_rdata(rd16), .out_valid(val16),
        .out_ready(out_ready), .out_data(od16), .out_last(last16));

    fib_sram_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .busy(busy8), .done(done8),
        .overflow(ovf8), .mismatch(mis8), .mem_we(we8), .mem_oe(oe8),
        .mem_addr(addr8), .mem_wdata(wd8), .mem_rdata(rd8), .out_valid(val8),
        .out_ready(out_ready), .out_data(od8), .out_last(last8));

    // SRAM models: registered read data, zero when oe was low at the edge.
    logic [7:0] mem16 [16];
    logic [7:0] mem8 [8];
    always @(posedge clk) begin
        if (we16) mem16[addr16] <= wd16;
        rd16 <= oe16 ? ((corrupt4 && addr16 == 4'd4) ? 8'hFF : mem16[addr16]) : 8'h00;
        if (we8) mem8[addr8] <= wd8;
        rd8 <= oe8 ? mem8[addr8] : 8'h00;
    end

    logic       v_busy, v_done, v_ovf, v_mis, v_we, v_oe, v_valid, v_last;
    logic [3:0] v_addr;
    logic [7:0] v_wdata, v_data;
    always_comb begin
        if (sel8) begin
            {v_busy, v_done, v_ovf, v_mis, v_we, v_oe, v_valid, v_last} =
                {busy8, done8, ovf8, mis8, we8, oe8, val8, last8};
            v_addr = {1'b0, addr8}; v_wdata = wd8; v_data = od8;
        end else begin
            {v_busy, v_done, v_ovf, v_mis, v_we, v_oe, v_valid, v_last} =
                {busy16, done16, ovf16, mis16, we16, oe16, val16, last16};
            v_addr = addr16; v_wdata = wd16; v_data = od16;
        end
    end

    int vectors = 0, errors = 0;
    int done_cyc, fv_cyc, stalls, viol;
    bit ovf_end, mis_end, mis_early, exp_ovf;
    logic [7:0] beat_q[$], wdat_q[$], held_q[$], exp_q[$];
    logic       last_q[$];
    int         wadr_q[$];

    // Reference: Fibonacci sequence in DATA_WIDTH=8 modular arithmetic, overflow if any sum exceeds 255.
    function automatic void build_model(input int depth);
        int a, b, s;
        a = 0; b = 1; exp_ovf = 0;
        exp_q.delete();
        for (int i = 0; i < depth; i++) begin
            exp_q.push_back(8'(a));
            if (a + b > 255) exp_ovf = 1;
            s = (a + b) % 256;
            a = b;
            b = s;
        end
    endfunction

    // One full run: mode 0 ready=1, mode 1 stall 3rd beat for stall_len cycles, mode 2 random ready.
    task automatic run(input bit use8, input int mode, input int stall_len, input bit poke);
        int stall_cnt = 0;
        bit done_seen = 0, prev_hold = 0;
        logic [7:0] prev_data = '0;
        beat_q.delete(); last_q.delete(); wdat_q.delete(); wadr_q.delete(); held_q.delete();
        done_cyc = -1; fv_cyc = -1; stalls = 0; viol = 0;
        @(negedge clk);
        sel8 = use8; start = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 3000 && !done_seen; c++) begin
            @(negedge clk);
            start = poke && (c == 5 || (v_valid && beat_q.size() == 3));
            if (c == 0) mis_early = v_mis;
            if (v_we && v_oe) viol++;
            if (!v_we && v_wdata != 8'h00) viol++;
            if (!v_we && !v_oe && v_addr != 4'd0) viol++;
            if (v_valid && v_oe) viol++;
            if (prev_hold && (!v_valid || v_data != prev_data)) viol++;
            if (v_we) begin wadr_q.push_back(int'(v_addr)); wdat_q.push_back(v_wdata); end
            if (v_valid && fv_cyc < 0) fv_cyc = c;
            if (v_done) begin done_cyc = c; done_seen = 1; end
            case (mode)
                1:       out_ready = !(v_valid && beat_q.size() == 2 && stall_cnt < stall_len);
                2:       out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 1'b1;
            endcase
            if (mode == 1 && !out_ready) stall_cnt++;
            if (v_valid && !out_ready) begin stalls++; held_q.push_back(v_data); end
            if (v_valid && out_ready) begin beat_q.push_back(v_data); last_q.push_back(v_last); end
            prev_hold = v_valid && !out_ready;
            prev_data = v_data;
        end
        ovf_end = v_ovf; mis_end = v_mis;
        start = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy16, done16, ovf16, mis16, we16, oe16, addr16, wd16, val16, last16, od16} !== '0) begin
            errors++; $display("FAIL reset16 outputs not all zero (busy=%b we=%b oe=%b valid=%b)", busy16, we16, oe16, val16);
        end
        vectors++;
        if ({busy8, done8, ovf8, mis8, we8, oe8, addr8, wd8, val8, last8, od8} !== '0) begin
            errors++; $display("FAIL reset8 outputs not all zero (busy=%b we=%b oe=%b valid=%b)", busy8, we8, oe8, val8);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        run(1'b0, 0, 0, 1'b0);
        vectors++;
        if (wadr_q.size() != 16) begin errors++; $display("FAIL basic write count got %0d want 16", wadr_q.size()); end
        for (int i = 0; i < 16 && i < wadr_q.size(); i++) begin
            vectors++;
            if (wadr_q[i] != i || wdat_q[i] !== fib16[i]) begin
                errors++; $display("FAIL basic write %0d got addr %0d data %0d want addr %0d data %0d", i, wadr_q[i], wdat_q[i], i, fib16[i]);
            end
        end
        vectors++;
        if (beat_q.size() != 16) begin errors++; $display("FAIL basic beat count got %0d want 16", beat_q.size()); end
        for (int i = 0; i < 16 && i < beat_q.size(); i++) begin
            vectors++;
            if (beat_q[i] !== fib16[i] || last_q[i] !== (i == 15)) begin
                errors++; $display("FAIL basic beat %0d got %0d last %b want %0d last %b", i, beat_q[i], last_q[i], fib16[i], i == 15);
            end
        end
        vectors++;
        if (fv_cyc != 18) begin errors++; $display("FAIL basic first valid cycle got %0d want 18", fv_cyc); end
        vectors++;
        if (done_cyc != 65) begin errors++; $display("FAIL basic done cycle got %0d want 65", done_cyc); end
        vectors++;
        if (ovf_end !== 1'b1 || mis_end !== 1'b0) begin
            errors++; $display("FAIL basic flags got ovf=%b mis=%b want ovf=1 mis=0", ovf_end, mis_end);
        end
        vectors++;
        if (viol != 0) begin errors++; $display("FAIL basic protocol violations got %0d want 0", viol); end
    endtask

    task automatic test_backpressure;
        run(1'b0, 1, 5, 1'b0);
        vectors++;
        if (held_q.size() != 5) begin errors++; $display("FAIL bp stall cycles got %0d want 5", held_q.size()); end
        foreach (held_q[i]) begin
            vectors++;
            if (held_q[i] !== 8'd1) begin errors++; $display("FAIL bp held data %0d got %0d want 1", i, held_q[i]); end
        end
        vectors++;
        if (beat_q.size() != 16) begin errors++; $display("FAIL bp beat count got %0d want 16", beat_q.size()); end
        for (int i = 0; i < 16 && i < beat_q.size(); i++) begin
            vectors++;
            if (beat_q[i] !== fib16[i]) begin errors++; $display("FAIL bp beat %0d got %0d want %0d", i, beat_q[i], fib16[i]); end
        end
        vectors++;
        if (done_cyc != 70) begin errors++; $display("FAIL bp done cycle got %0d want 70", done_cyc); end
        vectors++;
        if (viol != 0) begin errors++; $display("FAIL bp protocol violations got %0d want 0", viol); end
    endtask

    task automatic test_small_depth;
        run(1'b1, 0, 0, 1'b0);
        vectors++;
        if (beat_q.size() != 8) begin errors++; $display("FAIL aw3 beat count got %0d want 8", beat_q.size()); end
        for (int i = 0; i < 8 && i < beat_q.size(); i++) begin
            vectors++;
            if (beat_q[i] !== fib16[i] || last_q[i] !== (i == 7)) begin
                errors++; $display("FAIL aw3 beat %0d got %0d last %b want %0d last %b", i, beat_q[i], last_q[i], fib16[i], i == 7);
            end
        end
        vectors++;
        if (done_cyc != 33 || fv_cyc != 10) begin
            errors++; $display("FAIL aw3 timing got done %0d valid %0d want done 33 valid 10", done_cyc, fv_cyc);
        end
        vectors++;
        if (ovf_end !== 1'b0) begin errors++; $display("FAIL aw3 overflow got %b want 0", ovf_end); end
    endtask

    task automatic test_start_ignored;
        run(1'b0, 0, 0, 1'b1);
        vectors++;
        if (wadr_q.size() != 16 || beat_q.size() != 16) begin
            errors++; $display("FAIL poke counts got writes %0d beats %0d want 16 16", wadr_q.size(), beat_q.size());
        end
        for (int i = 0; i < 16 && i < beat_q.size(); i++) begin
            vectors++;
            if (beat_q[i] !== fib16[i]) begin errors++; $display("FAIL poke beat %0d got %0d want %0d", i, beat_q[i], fib16[i]); end
        end
        vectors++;
        if (done_cyc != 65) begin errors++; $display("FAIL poke done cycle got %0d want 65", done_cyc); end
    endtask

    task automatic test_reset_mid_run;
        bit found = 0;
        int dones = 0;
        @(negedge clk);
        sel8 = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            if (we16 && addr16 == 4'd6) found = 1; else @(negedge clk);
        end
        vectors++;
        if (!found) begin errors++; $display("FAIL rstmid never reached addr 6 got 0 want 1"); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({busy16, done16, ovf16, mis16, we16, oe16, addr16, wd16, val16, last16, od16} !== '0) begin
            errors++; $display("FAIL rstmid outputs not zero (busy=%b we=%b addr=%0d)", busy16, we16, addr16);
        end
        repeat (80) begin
            @(negedge clk);
            if (done16 || busy16) dones++;
        end
        vectors++;
        if (dones != 0) begin errors++; $display("FAIL rstmid spurious done/busy cycles got %0d want 0", dones); end
        run(1'b0, 0, 0, 1'b0);
        vectors++;
        if (beat_q.size() != 16 || done_cyc != 65) begin
            errors++; $display("FAIL rstmid rerun got beats %0d done %0d want 16 65", beat_q.size(), done_cyc);
        end
        for (int i = 0; i < 16 && i < beat_q.size(); i++) begin
            vectors++;
            if (beat_q[i] !== fib16[i]) begin errors++; $display("FAIL rstmid beat %0d got %0d want %0d", i, beat_q[i], fib16[i]); end
        end
    endtask

    task automatic test_readback;
        corrupt4 = 1'b1;
        run(1'b0, 0, 0, 1'b0);
        corrupt4 = 1'b0;
        for (int i = 0; i < 16 && i < beat_q.size(); i++) begin
            vectors++;
            if (beat_q[i] !== ((i == 4) ? 8'hFF : fib16[i])) begin
                errors++; $display("FAIL rbk beat %0d got %0h want %0h", i, beat_q[i], (i == 4) ? 8'hFF : fib16[i]);
            end
        end
        vectors++;
        if (mis_end !== EXP_MIS) begin errors++; $display("FAIL rbk mismatch after run got %b want %b", mis_end, EXP_MIS); end
        repeat (3) @(negedge clk);
        vectors++;
        if (mis16 !== EXP_MIS) begin errors++; $display("FAIL rbk mismatch sticky got %b want %b", mis16, EXP_MIS); end
        run(1'b0, 0, 0, 1'b0);
        vectors++;
        if (mis_early !== 1'b0 || mis_end !== 1'b0) begin
            errors++; $display("FAIL rbk mismatch clear got early %b end %b want 0 0", mis_early, mis_end);
        end
    endtask

    task automatic test_random;
        for (int r = 0; r < 4; r++) begin
            bit   use8  = bit'($urandom_range(0, 1));
            int   depth = use8 ? 8 : 16;
            build_model(depth);
            run(use8, 2, 0, 1'b0);
            vectors++;
            if (beat_q.size() != depth) begin errors++; $display("FAIL rnd%0d beat count got %0d want %0d", r, beat_q.size(), depth); end
            for (int i = 0; i < depth && i < beat_q.size(); i++) begin
                vectors++;
                if (beat_q[i] !== exp_q[i] || last_q[i] !== (i == depth - 1)) begin
                    errors++; $display("FAIL rnd%0d beat %0d got %0d last %b want %0d last %b", r, i, beat_q[i], last_q[i], exp_q[i], i == depth - 1);
                end
            end
            vectors++;
            if (done_cyc != 4 * depth + 1 + stalls) begin
                errors++; $display("FAIL rnd%0d done cycle got %0d want %0d", r, done_cyc, 4 * depth + 1 + stalls);
            end
            vectors++;
            if (ovf_end !== exp_ovf || viol != 0) begin
                errors++; $display("FAIL rnd%0d ovf/protocol got ovf %b viol %0d want ovf %b viol 0", r, ovf_end, viol, exp_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_small_depth();
        test_start_ignored();
        test_reset_mid_run();
        test_readback();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
